// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp codes shared with the highway/country controller and conditioner FSM states
package traffic_pkg;
  typedef enum logic [1:0] {
    LAMP_RED    = 2'd0,
    LAMP_YELLOW = 2'd1,
    LAMP_GREEN  = 2'd2
  } lamp_t;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVE   = 2'd2,
    RELEASE = 2'd3
  } cond_state_t;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchroniser plus debounce of the raw loop detector
//   clk, clear_n (async active-low) ; sensor_raw (asynchronous, may glitch)
//   deb_level : debounced level ; arrival : one-cycle pulse on deb_level 0->1
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic clear_n,
  input  logic sensor_raw,
  output logic deb_level,
  output logic arrival
);
  localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  logic          s_meta;
  logic          s_sync;
  logic          deb_prev;
  logic [DW-1:0] deb_cnt;
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      s_meta    <= 1'b0;
      s_sync    <= 1'b0;
      deb_prev  <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      s_meta   <= sensor_raw;
      s_sync   <= s_meta;
      deb_prev <= deb_level;
      if (s_sync == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_level <= ~deb_level;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end
  assign arrival = deb_level & ~deb_prev;
endmodule

// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner: turns the country-road loop detector into the controller's car request x
//   clk, clear_n (async active-low) ; sensor_raw (raw detector) ; cntry_lamp (controller country lamp)
//   x : registered request, high in REQ and SERVE ; car_count : saturating arrival count
//   Build option CAR_COUNT_EN: enables car_count, otherwise car_count is tied to 0.
module car_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int HOLD_MAX   = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             sensor_raw,
  input  logic [1:0]       cntry_lamp,
  output logic             x,
  output logic [CNT_W-1:0] car_count
);
  localparam int HW = HOLD_MAX > 1 ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  logic          deb_level;
  logic          arrival;
  logic [HW-1:0] hold_cnt;
  cond_state_t   state;
  cond_state_t   state_nx;
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk        (clk),
    .clear_n    (clear_n),
    .sensor_raw (sensor_raw),
    .deb_level  (deb_level),
    .arrival    (arrival)
  );
  // Lamp code 3 is treated as non-green: only an exact GREEN match serves.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (arrival || deb_level) ? REQ : IDLE;
      REQ:     state_nx = (cntry_lamp == LAMP_GREEN) ? SERVE : REQ;
      SERVE:   state_nx = (!deb_level || hold_cnt == HOLD_LAST || cntry_lamp != LAMP_GREEN) ? RELEASE : SERVE;
      RELEASE: state_nx = (cntry_lamp == LAMP_RED) ? IDLE : RELEASE;
      default: state_nx = IDLE;
    endcase
  end
  // x is registered from the next state so it changes on the same edge as state.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state    <= IDLE;
      x        <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      x        <= (state_nx == REQ) || (state_nx == SERVE);
      hold_cnt <= (state == SERVE && state_nx == SERVE) ? hold_cnt + 1'b1 : '0;
    end
  end
`ifdef CAR_COUNT_EN
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) car_count <= '0;
    else if (arrival && !(&car_count)) car_count <= car_count + 1'b1;
  end
`else
  assign car_count = '0;
`endif
endmodule

// File: tb/tb_car_sensor_conditioner.sv
// tb_car_sensor_conditioner: directed self-checking bench for car_sensor_conditioner
module tb_car_sensor_conditioner;
  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       sensor_raw = 1'b0;
  logic [1:0] cntry_lamp = 2'd0;
  logic       x;
  logic [1:0] car_count;
  int passed = 0;
  int total = 0;
  typedef struct {
    logic       s;
    logic [1:0] lamp;
    logic       ex;
  } vec_t;
  vec_t vecs[12];
  car_sensor_conditioner #(.DEB_CYCLES(4), .HOLD_MAX(16), .CNT_W(2)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .sensor_raw (sensor_raw),
    .cntry_lamp (cntry_lamp),
    .x          (x),
    .car_count  (car_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic cyc(input logic s, input logic [1:0] l);
    sensor_raw = s;
    cntry_lamp = l;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [1:0] exp_cnt;
    for (int i = 0; i < 12; i++) vecs[i] = '{s: 1'b1, lamp: 2'd0, ex: (i >= 6)};
    #1;
    chk("reset_x", {31'd0, x}, 0);
    chk("reset_count", {30'd0, car_count}, 0);
    repeat (2) @(posedge clk);
    #1;
    clear_n = 1'b1;
    // glitch shorter than the debounce window
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 2'd0);
      chk("glitch_x", {31'd0, x}, 0);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 2'd0);
      chk("glitch_after_x", {31'd0, x}, 0);
    end
    // latency table: x rises on edge 6
    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].s, vecs[i].lamp);
      chk($sformatf("latency_e%0d", i), {31'd0, x}, {31'd0, vecs[i].ex});
    end
    // request stays latched while red even after the car leaves
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 2'd0);
      chk("latch_x", {31'd0, x}, 1);
    end
    cyc(1'b0, 2'd2);
    chk("serve_entry_x", {31'd0, x}, 1);
    cyc(1'b0, 2'd2);
    chk("serve_exit_nocar_x", {31'd0, x}, 0);
    cyc(1'b0, 2'd0);
    chk("idle_x", {31'd0, x}, 0);
    // hold cap and re-request
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 2'd0);
      chk("cap_req_x", {31'd0, x}, (i >= 6) ? 1 : 0);
    end
    for (int i = 1; i <= 17; i++) begin
      cyc(1'b1, 2'd2);
      chk($sformatf("cap_serve_c%0d", i), {31'd0, x}, (i <= 16) ? 1 : 0);
    end
    cyc(1'b1, 2'd1);
    chk("release_yellow_x", {31'd0, x}, 0);
    cyc(1'b1, 2'd1);
    chk("release_yellow2_x", {31'd0, x}, 0);
    cyc(1'b1, 2'd0);
    chk("rereq_idle_x", {31'd0, x}, 0);
    cyc(1'b1, 2'd0);
    chk("rereq_x", {31'd0, x}, 1);
    // asynchronous reset mid-SERVE
    cyc(1'b1, 2'd2);
    cyc(1'b1, 2'd2);
    chk("pre_reset_serve_x", {31'd0, x}, 1);
    #2;
    clear_n = 1'b0;
    #1;
    chk("async_reset_x", {31'd0, x}, 0);
    chk("async_reset_count", {30'd0, car_count}, 0);
    cntry_lamp = 2'd0;
    @(posedge clk);
    #1;
    chk("reset_held_x", {31'd0, x}, 0);
    clear_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 2'd0);
      chk($sformatf("post_reset_e%0d", i), {31'd0, x}, (i >= 6) ? 1 : 0);
    end
    // arrival counting
    sensor_raw = 1'b0;
    clear_n = 1'b0;
    #1;
    chk("count_reset", {30'd0, car_count}, 0);
    @(posedge clk);
    #1;
    clear_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      repeat (8) cyc(1'b1, 2'd0);
      repeat (8) cyc(1'b0, 2'd0);
`ifdef CAR_COUNT_EN
      exp_cnt = (k < 3) ? 2'(k) : 2'd3;
`else
      exp_cnt = 2'd0;
`endif
      chk($sformatf("car_count_p%0d", k), {30'd0, car_count}, {30'd0, exp_cnt});
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
